// File: rtl/winograd_out_tf_pkg.sv
// Shared constants and types for the Winograd F(2,3) output transform.
package winograd_out_tf_pkg;
  localparam int TILE_N  = 4;
  localparam int OUT_N   = 2;
  localparam int DATA_W  = 32;
  localparam int ACC_W   = 64;
  localparam int KADDR_W = 4;

  typedef logic [KADDR_W-1:0]       kaddr_t;
  typedef logic signed [DATA_W-1:0] data_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  // Position of the next expected column inside the current tile.
  typedef enum logic [1:0] {
    COL0 = 2'd0,
    COL1 = 2'd1,
    COL2 = 2'd2,
    COL3 = 2'd3
  } col_t;
endpackage

// File: rtl/winograd_out_tf_if.sv
// Column-input, kernel-write and 2x2 output bundle of winograd_out_tf.
interface winograd_out_tf_if;
  import winograd_out_tf_pkg::*;

  logic   in_valid;
  data_t  in_1, in_2, in_3, in_4;
  logic   k_we;
  kaddr_t k_addr;
  data_t  k_data;
  logic   k_ready;
  logic   out_valid;
  data_t  y_1, y_2, y_3, y_4;

  modport master (
    output in_valid, in_1, in_2, in_3, in_4, k_we, k_addr, k_data,
    input  k_ready, out_valid, y_1, y_2, y_3, y_4
  );

  modport slave (
    input  in_valid, in_1, in_2, in_3, in_4, k_we, k_addr, k_data,
    output k_ready, out_valid, y_1, y_2, y_3, y_4
  );
endinterface

// File: rtl/winograd_out_tf_kstore.sv
// wino_kstore: 16-entry transformed-kernel register file, gated writes,
// four parallel read ports returning column `col` of U.
module wino_kstore
  import winograd_out_tf_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   we,
  input  logic   wr_ok,
  input  kaddr_t waddr,
  input  data_t  wdata,
  input  col_t   col,
  output data_t  u [TILE_N]
);
  data_t coef_q [TILE_N*TILE_N];
  data_t coef_d [TILE_N*TILE_N];

  always_comb begin
    coef_d = coef_q;
    if (we && wr_ok) coef_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) coef_q <= '{default: '0};
    else      coef_q <= coef_d;
  end

  // Address layout is {row, column}, so each read port fixes the row.
  always_comb begin
    for (int i = 0; i < TILE_N; i++) u[i] = coef_q[{i[1:0], col}];
  end
endmodule

// File: rtl/winograd_out_tf.sv
// Winograd F(2,3) output transform: Hadamard with stored U, then A^T*M*A
// accumulated column by column. Define WINO_OUT_SAT_EN to saturate outputs.
module winograd_out_tf
  import winograd_out_tf_pkg::*;
#(
  parameter int FRAC = 0
)(
  input logic              clk,
  input logic              rst,
  winograd_out_tf_if.slave bus
);
  col_t  col_q, col_d;
  acc_t  acc0_q [OUT_N], acc0_d [OUT_N];
  acc_t  acc1_q [OUT_N], acc1_d [OUT_N];
  data_t y_q [TILE_N], y_d [TILE_N];
  logic  out_valid_q, out_valid_d;
  logic  k_ready;
  data_t u [TILE_N];
  acc_t  m [TILE_N];
  acc_t  t [OUT_N];

  function automatic data_t out_conv(input acc_t a);
    acc_t s;
    s = a >>> FRAC;
`ifdef WINO_OUT_SAT_EN
    if (s > ((acc_t'(1) <<< (DATA_W-1)) - acc_t'(1))) return {1'b0, {(DATA_W-1){1'b1}}};
    if (s < -(acc_t'(1) <<< (DATA_W-1)))              return {1'b1, {(DATA_W-1){1'b0}}};
`endif
    return data_t'(s);
  endfunction

  assign k_ready = (col_q == COL0) && !bus.in_valid;

  wino_kstore u_kstore (
    .clk   (clk),
    .rst   (rst),
    .we    (bus.k_we),
    .wr_ok (k_ready),
    .waddr (bus.k_addr),
    .wdata (bus.k_data),
    .col   (col_q),
    .u     (u)
  );

  // Hadamard product and A^T row combine for the column on the inputs.
  assign m[0] = acc_t'(bus.in_1) * acc_t'(u[0]);
  assign m[1] = acc_t'(bus.in_2) * acc_t'(u[1]);
  assign m[2] = acc_t'(bus.in_3) * acc_t'(u[2]);
  assign m[3] = acc_t'(bus.in_4) * acc_t'(u[3]);
  assign t[0] = m[0] + m[1] + m[2];
  assign t[1] = m[1] - m[2] - m[3];

  always_comb begin
    col_d       = col_q;
    acc0_d      = acc0_q;
    acc1_d      = acc1_q;
    y_d         = y_q;
    out_valid_d = 1'b0;
    if (bus.in_valid) begin
      for (int r = 0; r < OUT_N; r++) begin
        case (col_q)
          COL0: begin acc0_d[r] = t[r];             acc1_d[r] = '0;                end
          COL1: begin acc0_d[r] = acc0_q[r] + t[r]; acc1_d[r] = acc1_q[r] + t[r]; end
          COL2: begin acc0_d[r] = acc0_q[r] + t[r]; acc1_d[r] = acc1_q[r] - t[r]; end
          default:                                  acc1_d[r] = acc1_q[r] - t[r];
        endcase
      end
      case (col_q)
        COL0:    col_d = COL1;
        COL1:    col_d = COL2;
        COL2:    col_d = COL3;
        default: col_d = COL0;
      endcase
      // Last column closes the tile: register the block from updated sums.
      if (col_q == COL3) begin
        out_valid_d = 1'b1;
        y_d[0] = out_conv(acc0_d[0]);
        y_d[1] = out_conv(acc1_d[0]);
        y_d[2] = out_conv(acc0_d[1]);
        y_d[3] = out_conv(acc1_d[1]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      col_q       <= COL0;
      acc0_q      <= '{default: '0};
      acc1_q      <= '{default: '0};
      y_q         <= '{default: '0};
      out_valid_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      acc0_q      <= acc0_d;
      acc1_q      <= acc1_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.k_ready   = k_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.y_1       = y_q[0];
  assign bus.y_2       = y_q[1];
  assign bus.y_3       = y_q[2];
  assign bus.y_4       = y_q[3];
endmodule

// File: tb/tb_winograd_out_tf.sv
// Bench for winograd_out_tf: matrix-level reference (Y = A^T (U.*V) A) plus
// directed literal cases and randomized traffic.
module tb_winograd_out_tf;
  import winograd_out_tf_pkg::*;

  localparam int FRAC_TB = 0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  winograd_out_tf_if bus ();

  winograd_out_tf #(.FRAC(FRAC_TB)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int     Um [4][4];
  longint Mm [4][4];
  int     mcol = 0;
  int     exp_y [4];
  bit     exp_ov = 1'b0;
  bit     armed = 1'b0;
  int     AT [2][4] = '{'{1, 1, 1, 0}, '{0, 1, -1, -1}};

  function automatic int conv(input longint a);
    longint s;
    s = a >>> FRAC_TB;
`ifdef WINO_OUT_SAT_EN
    if (s > 64'sd2147483647)  return 32'sh7FFFFFFF;
    if (s < -64'sd2147483648) return 32'sh80000000;
`endif
    return int'(s);
  endfunction

  always @(posedge clk) begin
    int vin [4];
    longint s;
    exp_ov = 1'b0;
    if (!rst) begin
      armed = 1'b1;
      mcol  = 0;
      for (int i = 0; i < 4; i++) begin
        exp_y[i] = 0;
        for (int k = 0; k < 4; k++) Um[i][k] = 0;
      end
    end else if (bus.in_valid) begin
      vin = '{bus.in_1, bus.in_2, bus.in_3, bus.in_4};
      for (int i = 0; i < 4; i++) Mm[i][mcol] = longint'(vin[i]) * longint'(Um[i][mcol]);
      if (mcol == 3) begin
        for (int r = 0; r < 2; r++)
          for (int c = 0; c < 2; c++) begin
            s = 0;
            for (int i = 0; i < 4; i++)
              for (int k = 0; k < 4; k++)
                s += longint'(AT[r][i] * AT[c][k]) * Mm[i][k];
            exp_y[r*2+c] = conv(s);
          end
        exp_ov = 1'b1;
      end
      mcol = (mcol + 1) % 4;
    end else if (bus.k_we && mcol == 0) begin
      Um[bus.k_addr[3:2]][bus.k_addr[1:0]] = bus.k_data;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("out_valid", longint'(bus.out_valid), longint'(exp_ov));
      chk("k_ready", longint'(bus.k_ready), longint'(mcol == 0 && !bus.in_valid));
      chk("y_1", longint'(bus.y_1), longint'(exp_y[0]));
      chk("y_2", longint'(bus.y_2), longint'(exp_y[1]));
      chk("y_3", longint'(bus.y_3), longint'(exp_y[2]));
      chk("y_4", longint'(bus.y_4), longint'(exp_y[3]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_col(input int a, input int b, input int c, input int d);
    bus.in_valid = 1'b1;
    bus.in_1 = a; bus.in_2 = b; bus.in_3 = c; bus.in_4 = d;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic tile_const(input int v);
    for (int k = 0; k < 4; k++) send_col(v, v, v, v);
  endtask

  task automatic write_k(input int addr, input int data);
    bus.k_we = 1'b1;
    bus.k_addr = kaddr_t'(addr);
    bus.k_data = data;
    step();
    bus.k_we = 1'b0;
  endtask

  task automatic load_all(input int v);
    for (int a = 0; a < 16; a++) write_k(a, v);
  endtask

  task automatic chk_y(input string name, input int e1, input int e2, input int e3, input int e4);
    chk({name, "_ov"}, longint'(bus.out_valid), 1);
    chk({name, "_y1"}, longint'(bus.y_1), longint'(e1));
    chk({name, "_y2"}, longint'(bus.y_2), longint'(e2));
    chk({name, "_y3"}, longint'(bus.y_3), longint'(e3));
    chk({name, "_y4"}, longint'(bus.y_4), longint'(e4));
  endtask

  initial begin
    int ov_exp;
    bus.in_valid = 1'b0;
    bus.in_1 = '0; bus.in_2 = '0; bus.in_3 = '0; bus.in_4 = '0;
    bus.k_we = 1'b0; bus.k_addr = '0; bus.k_data = '0;
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;

    chk("rst_ov", longint'(bus.out_valid), 0);
    chk("rst_kready", longint'(bus.k_ready), 1);
    chk("rst_y1", longint'(bus.y_1), 0);
    chk("rst_y4", longint'(bus.y_4), 0);

    load_all(1);
    tile_const(1);
    chk_y("ones", 9, -3, -3, 1);

    send_col(1, 1, 1, 1);
    send_col(1, 1, 1, 1);
    repeat (3) step();
    send_col(1, 1, 1, 1);
    send_col(1, 1, 1, 1);
    chk_y("gap", 9, -3, -3, 1);
    step();
    chk("gap_pulse", longint'(bus.out_valid), 0);

    tile_const(1);
    chk_y("b2b_a", 9, -3, -3, 1);
    tile_const(0);
    chk_y("b2b_b", 0, 0, 0, 0);

    load_all(0);
    write_k(5, 5);
    tile_const(2);
    chk_y("u11", 10, 10, 10, 10);

    send_col(2, 2, 2, 2);
    send_col(2, 2, 2, 2);
    bus.k_we = 1'b1; bus.k_addr = 4'd5; bus.k_data = 99;
    #1;
    chk("kready_col2", longint'(bus.k_ready), 0);
    step();
    bus.k_we = 1'b0;
    send_col(2, 2, 2, 2);
    send_col(2, 2, 2, 2);
    chk_y("kdrop", 10, 10, 10, 10);

    send_col(1, 1, 1, 1);
    send_col(1, 1, 1, 1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("midrst_ov", longint'(bus.out_valid), 0);
    chk("midrst_y1", longint'(bus.y_1), 0);
    chk("midrst_y2", longint'(bus.y_2), 0);
    load_all(1);
    tile_const(1);
    chk_y("after_rst", 9, -3, -3, 1);

    load_all(0);
    write_k(0, 32'sh7FFFFFFF);
    send_col(32'sh7FFFFFFF, 0, 0, 0);
    send_col(0, 0, 0, 0);
    send_col(0, 0, 0, 0);
    send_col(0, 0, 0, 0);
`ifdef WINO_OUT_SAT_EN
    ov_exp = 32'sh7FFFFFFF;
`else
    ov_exp = 1;
`endif
    chk_y("ovf", ov_exp, 0, 0, 0);

    for (int n = 0; n < 3000; n++) begin
      bus.in_valid = ($urandom_range(0, 9) < 7);
      if (n < 1500) begin
        bus.in_1 = $signed($urandom_range(0, 2000)) - 1000;
        bus.in_2 = $signed($urandom_range(0, 2000)) - 1000;
        bus.in_3 = $signed($urandom_range(0, 2000)) - 1000;
        bus.in_4 = $signed($urandom_range(0, 2000)) - 1000;
      end else begin
        bus.in_1 = $urandom; bus.in_2 = $urandom; bus.in_3 = $urandom; bus.in_4 = $urandom;
      end
      bus.k_we   = ($urandom_range(0, 4) == 0);
      bus.k_addr = kaddr_t'($urandom_range(0, 15));
      bus.k_data = (n < 1500) ? ($signed($urandom_range(0, 200)) - 100) : $urandom;
      rst = ($urandom_range(0, 499) != 0);
      step();
    end
    bus.in_valid = 1'b0;
    bus.k_we = 1'b0;
    rst = 1'b1;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
